arith_dut_model: RTL and testbench
==================================

# arith_dut_model

- Synthesisable DUT-side responder for the arithmetic testbench.
- Sits on the far end of the DUT conduit: samples the operands the driver presents (`o_dut_a`/`o_dut_b`) and returns `i_dut_out` after a run-time-selectable pipeline latency.
- Optionally injects periodic bit faults, so the driver's delay measurement and the monitor/scoreboard error paths can be exercised on hardware without an external DUT.

## Interface
- `WIDTH`, 16: operand and result width.
- `MAX_LATENCY`, 8: pipeline depth and largest selectable latency; legal range 1..31.
- `clk_dut`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_dut_a`  in  WIDTH  operand A, sampled every cycle.
- `i_dut_b`  in  WIDTH  operand B, sampled every cycle.
- `i_op`  in  1  0 = A+B, 1 = A−B; sampled with the operands.
- `i_latency`  in  5  requested latency in cycles.
- `i_fault_period`  in  16  fault every N-th valid output; 0 disables.
- `i_fault_mask`  in  WIDTH  XOR mask applied to a faulted result.
- `o_dut_out`  out  WIDTH  registered result.
- `o_valid`  out  1  high once the pipeline holds L results computed under the current latency.
- `o_fault_ctr`  out  32  number of faults injected; saturating.

## Operation
- Effective latency L = clamp(`i_latency`, 1, `MAX_LATENCY`), held in register `lat_q`.
  - `i_latency` = 0 gives L = 1.
  - Values above `MAX_LATENCY` give L = `MAX_LATENCY`.
- Stage 0 captures `i_dut_a` ± `i_dut_b`, modulo 2^WIDTH.
  - Subtraction is two's complement, with wrap-around; no carry or borrow output.
- Results shift through stages 0..`MAX_LATENCY`−1 every cycle.
  - There is no stall; the stream never pauses.
- `o_dut_out` is registered from tap L−1, XORed with the fault mask when a fault fires.
- `i_op` travels with its operands, so toggling it mid-stream affects only the new samples.
- Latency change, i.e. clamp(`i_latency`) ≠ `lat_q` at an edge:
  - `lat_q` updates and the fill counter clears.
  - `o_valid` drops on the next edge.
  - The pipeline contents are not flushed; the output simply switches tap.
  - `o_valid` returns after L further cycles.
- Fill counter: increments each cycle while below L; `o_valid` = (fill == L).
- Fault engine:
  - The period counter advances only while `o_valid`=1.
  - When the counter reaches `i_fault_period`−1, that output is faulted, the counter wraps to 0, and `o_fault_ctr` increments.
  - `o_fault_ctr` holds at 0xFFFFFFFF.
  - `i_fault_period`=1 faults every valid output.
  - `i_fault_period`=0 holds the counter at 0 and never faults.
  - Writing a smaller period than the current count wraps the counter to 0 on the next advance, with no fault.
  - An all-zero mask still counts as a fault.

## Timing
- Operands present before edge k appear on `o_dut_out` immediately after edge k+L−1.
  - L=1 is a plain registered adder; L=2 matches the original internal adder.
- Reset, on an edge with `reset`=1:
  - All stages, `o_dut_out`, fill and period counters, and `o_fault_ctr` go to 0.
  - `o_valid` goes to 0.
  - `lat_q` loads clamp(`i_latency`).
- First valid output: `o_valid` rises after edge L following reset deassertion.
- Reset mid-stream behaves exactly as reset from idle; in-flight results are lost.
- Latency change and fault on the same edge: the latency change wins. No fault is injected and the counter is not advanced.
- Fault applies to the same cycle's output as the counter match; the counter wrap and the `o_fault_ctr` increment land on that same edge.

## Configuration
- `ARITH_DUT_MODEL_FAULT_EN` defined: the fault engine is present as described.
- Not defined:
  - No period counter or fault logic is built.
  - `o_dut_out` is always the true result.
  - `o_fault_ctr` is tied to 0.
  - `i_fault_period` and `i_fault_mask` are ignored.

## Test plan
- Reset, L=2, A=0x1234, B=0x0001, add:
  - `o_dut_out`=0x1235 two edges after sampling.
  - `o_valid` rises after edge 2.
- Wrap: A=0xFFFF, B=0x0002 add gives 0x0001. A=0x0000, B=0x0001 sub gives 0xFFFF.
- Latency sweep, `i_latency` = 0, 1, 5, 8, 20 with `MAX_LATENCY`=8:
  - Measured delays are 1, 1, 5, 8, 8.
  - `o_valid` stays low for L cycles after each change.
- Fault, with the macro defined: period 4, mask 0x0001, ramp input.
  - Every 4th valid output has its LSB flipped.
  - `o_fault_ctr`=25 after 100 valid outputs.
  - Period 0 gives no flips and a frozen counter.
- Reset asserted mid-stream with L=8: the next edge zeroes the output, `o_valid` and the counters. The first valid output is 8 edges after release.
- Macro undefined, period 1, mask 0xFFFF: outputs are always correct and `o_fault_ctr`=0.

Source files
------------

// File: rtl/arith_dut_model.sv
// arith_dut_model: DUT-side responder for the arithmetic test harness.
// Samples operands every cycle and returns A+B or A-B after a run-time
// selectable latency of 1..MAX_LATENCY cycles. MAX_LATENCY must be 1..31.
// Optional fault engine, built only when ARITH_DUT_MODEL_FAULT_EN is defined:
// it XORs a mask into every N-th valid output and counts injected faults.
module arith_dut_model #(
    parameter int WIDTH       = 16,
    parameter int MAX_LATENCY = 8
) (
    input  logic             clk_dut,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_dut_a,
    input  logic [WIDTH-1:0] i_dut_b,
    input  logic             i_op,
    input  logic [4:0]       i_latency,
    input  logic [15:0]      i_fault_period,
    input  logic [WIDTH-1:0] i_fault_mask,
    output logic [WIDTH-1:0] o_dut_out,
    output logic             o_valid,
    output logic [31:0]      o_fault_ctr
);

    localparam logic [4:0] MAX_LAT = 5'(MAX_LATENCY);

    logic [4:0]       lat_reg;
    logic [4:0]       lat_next;
    logic             lat_change;
    logic [4:0]       fill_reg;
    logic [4:0]       fill_next;
    logic             valid_reg;
    logic             valid_next;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] tap_next;
    logic [WIDTH-1:0] dut_out_reg;
    logic [WIDTH-1:0] dut_out_next;
    logic [WIDTH-1:0] stage_reg  [MAX_LATENCY];
    logic [WIDTH-1:0] stage_next [MAX_LATENCY];

    // Clamp the requested latency into 1..MAX_LATENCY
    always_comb begin
        lat_next = i_latency;
        if (i_latency == 5'd0) begin
            lat_next = 5'd1;
        end else if (i_latency > MAX_LAT) begin
            lat_next = MAX_LAT;
        end
    end

    assign lat_change = (lat_next != lat_reg);

    // Fill counter restarts on a latency change and saturates at L
    always_comb begin
        fill_next = fill_reg;
        if (lat_change) begin
            fill_next = 5'd0;
        end else if (fill_reg < lat_next) begin
            fill_next = fill_reg + 5'd1;
        end
    end

    // A change edge always yields an invalid output, so it can never fault
    assign valid_next = !lat_change && (fill_next == lat_next);

    // Two's complement wrap-around arithmetic, op travels with its operands
    assign sum_next = i_op ? (i_dut_a - i_dut_b) : (i_dut_a + i_dut_b);

    // Stage 0 takes the fresh result; later stages shift every cycle
    assign stage_next[0] = sum_next;
    genvar gi;
    generate
        for (gi = 1; gi < MAX_LATENCY; gi++) begin : g_shift
            assign stage_next[gi] = stage_reg[gi-1];
        end
    endgenerate

    // Pick the tap whose value lands on the output exactly L-1 edges after capture
    always_comb begin
        tap_next = stage_next[0];
        for (int i = 0; i < MAX_LATENCY; i++) begin
            if (lat_next == 5'(i + 1)) begin
                tap_next = stage_next[i];
            end
        end
    end

`ifdef ARITH_DUT_MODEL_FAULT_EN
    logic [15:0] period_cnt_reg;
    logic [15:0] period_cnt_next;
    logic        fault_fire;
    logic [31:0] fault_ctr_reg;

    // Period counter advances on valid outputs; a shrunk period wraps without a fault
    always_comb begin
        period_cnt_next = period_cnt_reg;
        fault_fire      = 1'b0;
        if (i_fault_period == 16'd0) begin
            period_cnt_next = 16'd0;
        end else if (valid_next) begin
            if (period_cnt_reg == i_fault_period - 16'd1) begin
                fault_fire      = 1'b1;
                period_cnt_next = 16'd0;
            end else if (period_cnt_reg > i_fault_period - 16'd1) begin
                period_cnt_next = 16'd0;
            end else begin
                period_cnt_next = period_cnt_reg + 16'd1;
            end
        end
    end

    assign dut_out_next = fault_fire ? (tap_next ^ i_fault_mask) : tap_next;

    // Fault bookkeeping; the injected-fault count saturates at all ones
    always_ff @(posedge clk_dut) begin
        if (reset) begin
            period_cnt_reg <= 16'd0;
            fault_ctr_reg  <= 32'd0;
        end else begin
            period_cnt_reg <= period_cnt_next;
            if (fault_fire && (fault_ctr_reg != 32'hFFFF_FFFF)) begin
                fault_ctr_reg <= fault_ctr_reg + 32'd1;
            end
        end
    end

    assign o_fault_ctr = fault_ctr_reg;
`else
    logic unused_fault_inputs;

    assign unused_fault_inputs = ^{i_fault_period, i_fault_mask};
    assign dut_out_next        = tap_next;
    assign o_fault_ctr         = 32'd0;
`endif

    // Pipeline, output register, fill tracking and latency register
    always_ff @(posedge clk_dut) begin
        if (reset) begin
            for (int i = 0; i < MAX_LATENCY; i++) begin
                stage_reg[i] <= '0;
            end
            dut_out_reg <= '0;
            fill_reg    <= 5'd0;
            valid_reg   <= 1'b0;
            lat_reg     <= lat_next;
        end else begin
            for (int i = 0; i < MAX_LATENCY; i++) begin
                stage_reg[i] <= stage_next[i];
            end
            dut_out_reg <= dut_out_next;
            fill_reg    <= fill_next;
            valid_reg   <= valid_next;
            lat_reg     <= lat_next;
        end
    end

    assign o_dut_out = dut_out_reg;
    assign o_valid   = valid_reg;

endmodule

// File: tb/tb_arith_dut_model.sv
// Scoreboard bench for arith_dut_model. The driver pushes one cycle record per
// edge and one expected result per sample that should emerge valid; the
// monitor pops and compares whenever the DUT presents an output.
module tb_arith_dut_model;
    localparam int W    = 16;
    localparam int MAXL = 8;

`ifdef ARITH_DUT_MODEL_FAULT_EN
    localparam bit FAULTS_BUILT = 1'b1;
`else
    localparam bit FAULTS_BUILT = 1'b0;
`endif

    logic          clk_dut = 1'b0;
    logic          reset;
    logic [W-1:0]  i_dut_a;
    logic [W-1:0]  i_dut_b;
    logic          i_op;
    logic [4:0]    i_latency;
    logic [15:0]   i_fault_period;
    logic [W-1:0]  i_fault_mask;
    logic [W-1:0]  o_dut_out;
    logic          o_valid;
    logic [31:0]   o_fault_ctr;

    always #5 clk_dut = ~clk_dut;

    arith_dut_model #(.WIDTH(W), .MAX_LATENCY(MAXL)) dut (
        .clk_dut        (clk_dut),
        .reset          (reset),
        .i_dut_a        (i_dut_a),
        .i_dut_b        (i_dut_b),
        .i_op           (i_op),
        .i_latency      (i_latency),
        .i_fault_period (i_fault_period),
        .i_fault_mask   (i_fault_mask),
        .o_dut_out      (o_dut_out),
        .o_valid        (o_valid),
        .o_fault_ctr    (o_fault_ctr)
    );

    typedef struct packed {
        logic rst;
        logic vld;
    } cyc_t;

    cyc_t         cq[$];
    logic [W-1:0] dq[$];

    int           checks = 0;
    int           errors = 0;
    int           cur_l = 1;
    int           since = 0;
    int           cur_period = 0;
    logic [W-1:0] cur_mask = '0;

    function automatic int clampl(input int raw);
        if (raw < 1) return 1;
        if (raw > MAXL) return MAXL;
        return raw;
    endfunction

    function automatic logic [W-1:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic op);
        int r;
        r = op ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        r = r % (1 << W);
        if (r < 0) r = r + (1 << W);
        return r[W-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One edge of stimulus; called at a falling edge, returns at the next one
    task automatic drive(input bit rst, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic op, input int lat_raw);
        int  newl;
        bit  boundary;
        newl      = clampl(lat_raw);
        reset     = rst;
        i_dut_a   = a;
        i_dut_b   = b;
        i_op      = op;
        i_latency = 5'(lat_raw);
        boundary  = rst || (newl != cur_l);
        cur_l     = newl;
        if (boundary) begin
            since = 0;
            dq.delete();
            cq.push_back('{rst: rst, vld: 1'b0});
        end else begin
            since++;
            cq.push_back('{rst: 1'b0, vld: (since >= cur_l)});
            dq.push_back(ref_calc(a, b, op));
        end
        @(negedge clk_dut);
    endtask

    task automatic rnd(input int lat_raw);
        drive(1'b0, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), lat_raw);
    endtask

    task automatic set_fault(input int p, input logic [W-1:0] m);
        cur_period     = p;
        cur_mask       = m;
        i_fault_period = 16'(p);
        i_fault_mask   = m;
    endtask

    // Monitor: compare every presented output against the scoreboard
    int           mon_n = 0;
    int           exp_faults = 0;
    cyc_t         mon_c;
    logic [W-1:0] mon_exp;
    bit           mon_flt;

    initial begin
        forever begin
            @(posedge clk_dut);
            #1;
            if (cq.size() > 0) begin
                mon_c = cq.pop_front();
                if (mon_c.rst) begin
                    mon_n      = 0;
                    exp_faults = 0;
                    chk("reset_out", 64'(o_dut_out), 64'd0);
                end
                chk("valid", 64'(o_valid), 64'(mon_c.vld));
                if (mon_c.vld && o_valid) begin
                    if (dq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL data_queue actual=empty expected=entry t=%0t", $time);
                    end else begin
                        mon_exp = dq.pop_front();
                        mon_n++;
                        mon_flt = FAULTS_BUILT && (cur_period != 0) && ((mon_n % cur_period) == 0);
                        if (mon_flt) begin
                            mon_exp    = mon_exp ^ cur_mask;
                            exp_faults = exp_faults + 1;
                        end
                        chk("data", 64'(o_dut_out), 64'(mon_exp));
                        $display("txn n=%0d L=%0d out=%04h exp=%04h flt=%0d",
                                 mon_n, cur_l, o_dut_out, mon_exp, mon_flt);
                        if (mon_n == 100 && cur_period == 4) begin
                            chk("ctr_after_100", 64'(o_fault_ctr), FAULTS_BUILT ? 64'd25 : 64'd0);
                        end
                    end
                end
                chk("fault_ctr", 64'(o_fault_ctr), 64'(exp_faults));
            end
        end
    end

    // Stimulus
    initial begin
        int lats[5];
        int lat;
        lats = '{0, 1, 5, 8, 20};
        reset          = 1'b1;
        i_dut_a        = '0;
        i_dut_b        = '0;
        i_op           = 1'b0;
        i_latency      = 5'd2;
        i_fault_period = 16'd0;
        i_fault_mask   = '0;

        // L=2 directed values, wrap cases, then random
        set_fault(0, 16'h0000);
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 2);
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 2);
        drive(1'b0, 16'h1234, 16'h0001, 1'b0, 2);
        drive(1'b0, 16'hFFFF, 16'h0002, 1'b0, 2);
        drive(1'b0, 16'h0000, 16'h0001, 1'b1, 2);
        repeat (20) rnd(2);

        // Latency sweep, including raw changes that clamp to the same L
        for (int k = 0; k < 5; k++) begin
            repeat (25) rnd(lats[k]);
        end

        // Periodic fault on a ramp
        set_fault(4, 16'h0001);
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 3);
        for (int i = 0; i < 120; i++) begin
            drive(1'b0, W'(i), 16'h0000, 1'b0, 3);
        end

        // Period 0: no flips, counter frozen
        set_fault(0, 16'hFFFF);
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 4);
        repeat (30) rnd(4);
        repeat (20) rnd(6);

        // Period 1 with a latency change while faults would fire
        set_fault(1, 16'hFFFF);
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 2);
        repeat (30) rnd(2);
        repeat (30) rnd(7);

        // Mid-stream reset at L=8, then random latency hopping
        set_fault(3, W'($urandom));
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 8);
        repeat (30) rnd(8);
        drive(1'b1, W'($urandom), W'($urandom), 1'b0, 8);
        repeat (30) rnd(8);
        repeat (6) begin
            lat = $urandom_range(0, 31);
            repeat ($urandom_range(3, 12)) rnd(lat);
        end

        repeat (2) @(negedge clk_dut);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
